// File: rtl/fma_pkg.sv
// Shared widths, control payload and shift-clamp helper for the FMA addend pre-normalizer.
package fma_pkg;

    function automatic int sig_w(input int mant);
        return mant + 1;
    endfunction

    function automatic int win_w(input int mant);
        return 3 * (mant + 1) + 2;
    endfunction

    function automatic int lsh_w(input int mant);
        return 2 * (mant + 1) + 2;
    endfunction

    function automatic int pd_v(input int mant);
        return mant + 4;
    endfunction

    typedef struct packed {
        logic a_sign;
        logic b_sign;
        logic c_sign;
        logic sub_sign;
        logic sign_flip;
        logic mv_halt;
        logic exp_mv_sign;
    } ctl_t;

    // A halted move never shifts; anything at or past lim pushes every bit out of the window.
    function automatic int unsigned clamp_shift(input logic [31:0] mv, input logic halt,
                                                input int unsigned lim);
        if (halt)
            return 0;
        else if (mv > lim)
            return lim;
        else
            return mv;
    endfunction

endpackage

// File: rtl/fma_prenorm_pipe_if.sv
// Operand/result bundle with input and output valid/ready handshakes for the addend pre-normalizer.
interface fma_prenorm_pipe_if #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
);
    import fma_pkg::*;

    localparam int SIG = sig_w(PARM_MANT);
    localparam int W   = win_w(PARM_MANT);

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  A_sign_i;
    logic                  B_sign_i;
    logic                  C_sign_i;
    logic                  Sub_Sign_i;
    logic                  Sign_flip_i;
    logic                  Mv_halt_i;
    logic                  Exp_mv_sign_i;
    logic [PARM_EXP-1:0]   A_Exp_i;
    logic [PARM_EXP-1:0]   B_Exp_i;
    logic [PARM_EXP-1:0]   C_Exp_i;
    logic [SIG-1:0]        A_Mant_i;
    logic [PARM_EXP+1:0]   Exp_mv_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  Sign_aligned_o;
    logic [PARM_EXP+1:0]   Exp_aligned_o;
    logic [W:0]            A_Mant_aligned_o;
    logic                  Mant_sticky_sht_out_o;

    modport slave (
        input  in_valid_i, A_sign_i, B_sign_i, C_sign_i, Sub_Sign_i, Sign_flip_i, Mv_halt_i,
               Exp_mv_sign_i, A_Exp_i, B_Exp_i, C_Exp_i, A_Mant_i, Exp_mv_i, out_ready_i,
        output in_ready_o, out_valid_o, Sign_aligned_o, Exp_aligned_o, A_Mant_aligned_o,
               Mant_sticky_sht_out_o
    );

    modport master (
        output in_valid_i, A_sign_i, B_sign_i, C_sign_i, Sub_Sign_i, Sign_flip_i, Mv_halt_i,
               Exp_mv_sign_i, A_Exp_i, B_Exp_i, C_Exp_i, A_Mant_i, Exp_mv_i, out_ready_i,
        input  in_ready_o, out_valid_o, Sign_aligned_o, Exp_aligned_o, A_Mant_aligned_o,
               Mant_sticky_sht_out_o
    );

endinterface

// File: rtl/fma_align_shift.sv
// Combinational addend right-shifter: aligned window, dropped field and sticky.
// No state, no handshake; latency 0.
module fma_align_shift #(
    parameter int SIG = 24,
    parameter int W   = 74,
    parameter int SHW = 7
) (
    input  logic [SIG-1:0] a_mant,
    input  logic [SHW-1:0] sh,
    input  logic           mv_halt,
    input  logic           sub_sign,
    input  logic           sign_flip,
    output logic [W-1:0]   aligned,
    output logic           sticky
);
    logic [W+SIG-1:0] t;
    logic [SIG-1:0]   drop;
    logic [SIG-1:0]   src;
    logic [SIG-1:0]   neg;
    logic             past;

    assign t       = {a_mant, {W{1'b0}}} >> sh;
    assign aligned = t[W+SIG-1:SIG];
    assign drop    = t[SIG-1:0];
    // Beyond W the window is empty, so every addend bit (some shifted out of t) belongs to sticky.
    assign past    = (sh > SHW'(W));

    always_comb begin
        src = drop;
        if (mv_halt || past)
            src = a_mant;
        neg    = ~src + SIG'(1);
        sticky = (sub_sign && !sign_flip) ? |neg : |src;
    end

endmodule

// File: rtl/fma_prenorm_pipe.sv
// Two-stage elastic addend pre-normalizer; latency 2, throughput 1/cycle.
// in_ready is combinational from out_ready; a full pipe with out_ready low holds both stages.
module fma_prenorm_pipe
    import fma_pkg::*;
#(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_BIAS = 127
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    fma_prenorm_pipe_if.slave io
);
    localparam int SIG   = sig_w(PARM_MANT);
    localparam int W     = win_w(PARM_MANT);
    localparam int LSH   = lsh_w(PARM_MANT);
    localparam int PD    = pd_v(PARM_MANT);
    localparam int SHMAX = W + SIG;
    localparam int SHW   = $clog2(SHMAX + 1);
    localparam int EW    = PARM_EXP + 2;

    logic                v1, v2, adv1, adv2;
    ctl_t                s1_ctl;
    logic [PARM_EXP-1:0] s1_a_exp, s1_b_exp, s1_c_exp;
    logic [SIG-1:0]      s1_a_mant;
    logic [SHW-1:0]      s1_sh, sh_next;

    logic [W-1:0]        aligned;
    logic                sticky;
    logic                sign2;
    logic [EW-1:0]       exp2;
    logic [W:0]          mant2;

    assign adv2          = !v2 || io.out_ready_i;
    assign adv1          = !v1 || adv2;
    assign io.in_ready_o = adv1;
    assign io.out_valid_o = v2;
    assign sh_next = SHW'(clamp_shift(32'(io.Exp_mv_i), io.Mv_halt_i, SHMAX));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1        <= 1'b0;
            s1_ctl    <= '0;
            s1_a_exp  <= '0;
            s1_b_exp  <= '0;
            s1_c_exp  <= '0;
            s1_a_mant <= '0;
            s1_sh     <= '0;
        end else begin
            if (flush_i)
                v1 <= 1'b0;
            else if (adv1)
                v1 <= io.in_valid_i;
            if (adv1 && io.in_valid_i && !flush_i) begin
                s1_ctl    <= '{a_sign: io.A_sign_i, b_sign: io.B_sign_i, c_sign: io.C_sign_i,
                               sub_sign: io.Sub_Sign_i, sign_flip: io.Sign_flip_i,
                               mv_halt: io.Mv_halt_i, exp_mv_sign: io.Exp_mv_sign_i};
                s1_a_exp  <= io.A_Exp_i;
                s1_b_exp  <= io.B_Exp_i;
                s1_c_exp  <= io.C_Exp_i;
                s1_a_mant <= io.A_Mant_i;
                s1_sh     <= sh_next;
            end
        end
    end

    fma_align_shift #(.SIG(SIG), .W(W), .SHW(SHW)) u_align_shift (
        .a_mant    (s1_a_mant),
        .sh        (s1_sh),
        .mv_halt   (s1_ctl.mv_halt),
        .sub_sign  (s1_ctl.sub_sign),
        .sign_flip (s1_ctl.sign_flip),
        .aligned   (aligned),
        .sticky    (sticky)
    );

    always_comb begin
        sign2 = s1_ctl.b_sign ^ s1_ctl.c_sign;
        exp2  = EW'(s1_b_exp) + EW'(s1_c_exp) - EW'(PARM_BIAS) + EW'(PD);
        mant2 = '0;
        if (s1_ctl.exp_mv_sign) begin
            sign2 = s1_ctl.a_sign;
            exp2  = EW'(s1_a_exp);
            mant2 = (W+1)'(s1_a_mant) << LSH;
        end else if (!s1_ctl.mv_halt) begin
            mant2 = {s1_ctl.sub_sign, {W{s1_ctl.sub_sign}} ^ aligned};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2                       <= 1'b0;
            io.Sign_aligned_o        <= 1'b0;
            io.Exp_aligned_o         <= '0;
            io.A_Mant_aligned_o      <= '0;
            io.Mant_sticky_sht_out_o <= 1'b0;
        end else begin
            if (flush_i)
                v2 <= 1'b0;
            else if (adv2)
                v2 <= v1;
            if (adv2 && v1 && !flush_i) begin
                io.Sign_aligned_o        <= sign2;
                io.Exp_aligned_o         <= exp2;
                io.A_Mant_aligned_o      <= mant2;
                io.Mant_sticky_sht_out_o <= sticky;
            end
        end
    end

endmodule
